// File: rtl/stonyman_pixel_sequencer_pkg.sv
// Shared definitions for the Stonyman pixel sequencer: FSM states, sensor
// pointer indices, pin-select encoding and counter widths.
package stonyman_defs;

    localparam int CNT_W    = 7;
    localparam int NUM_PINS = 4;

    // Sensor register pointer values after RESP/INCP
    localparam int PTR_COL = 0;
    localparam int PTR_ROW = 1;

    typedef enum logic [1:0] {
        PIN_RESP = 2'd0,
        PIN_INCP = 2'd1,
        PIN_RESV = 2'd2,
        PIN_INCV = 2'd3
    } pin_sel_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ROW_PTR,
        S_ROW_VAL,
        S_COL_PTR,
        S_SETTLE,
        S_CAPTURE,
        S_WAIT_DONE,
        S_COL_STEP,
        S_DONE
    } state_e;

    function automatic logic [NUM_PINS-1:0] pin_onehot(input pin_sel_e sel);
        logic [NUM_PINS-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/stonyman_pulse_gen.sv
// Emits N pulses on one selected sensor pin, each PULSE_CYCLES high then
// PULSE_CYCLES low. o_done flags the final low cycle so a follow-on go
// can start the next burst with no idle gap.
module stonyman_pulse_gen
    import stonyman_defs::*;
#(
    parameter int PULSE_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  pin_sel_e            i_sel,
    input  logic [CNT_W-1:0]    i_count,
    input  logic                i_go,
    output logic [NUM_PINS-1:0] o_pins,
    output logic                o_done
);

    localparam int TW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam logic [TW-1:0] T_LOAD = TW'(PULSE_CYCLES - 1);

    pin_sel_e            r_sel;
    logic [NUM_PINS-1:0] r_pins;
    logic [TW-1:0]       r_timer;
    logic [CNT_W-1:0]    r_left;
    logic                r_high;
    logic                r_active;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sel    <= PIN_RESP;
            r_pins   <= '0;
            r_timer  <= '0;
            r_left   <= '0;
            r_high   <= 1'b0;
            r_active <= 1'b0;
        end else if (i_go && i_count != '0) begin
            r_sel    <= i_sel;
            r_pins   <= pin_onehot(i_sel);
            r_timer  <= T_LOAD;
            r_left   <= i_count - 1'b1;
            r_high   <= 1'b1;
            r_active <= 1'b1;
        end else if (r_active) begin
            if (r_timer != '0) begin
                r_timer <= r_timer - 1'b1;
            end else if (r_high) begin
                r_pins  <= '0;
                r_high  <= 1'b0;
                r_timer <= T_LOAD;
            end else if (r_left != '0) begin
                r_left  <= r_left - 1'b1;
                r_pins  <= pin_onehot(r_sel);
                r_high  <= 1'b1;
                r_timer <= T_LOAD;
            end else begin
                r_active <= 1'b0;
            end
        end
    end

    assign o_pins = r_pins;
    assign o_done = r_active && !r_high && (r_timer == '0) && (r_left == '0);

endmodule

// File: rtl/stonyman_pixel_sequencer.sv
// Raster-scans one Stonyman frame: positions the sensor row/column through
// RESP/INCP/RESV/INCV, settles, then handshakes each pixel with adc_controller.
module stonyman_pixel_sequencer
    import stonyman_defs::*;
#(
    parameter int ROWS          = 112,
    parameter int COLS          = 112,
    parameter int PULSE_CYCLES  = 2,
    parameter int SETTLE_CYCLES = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic frame_start,
    output logic frame_busy,
    output logic frame_done,
    output logic resp,
    output logic incp,
    output logic resv,
    output logic incv,
    output logic adc_capture_start,
    input  logic adc_capture_done
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SW-1:0]    SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LAST_ROW    = CNT_W'(ROWS - 1);
    localparam logic [CNT_W-1:0] LAST_COL    = CNT_W'(COLS - 1);
    // RESP leaves the pointer at column select; this many INCPs reach row select
    localparam logic [CNT_W-1:0] ROW_PTR_INCS = CNT_W'(PTR_ROW - PTR_COL);

    state_e           r_state, w_state_n;
    logic             r_phase, w_phase_n;
    logic [CNT_W-1:0] r_row, w_row_n;
    logic [CNT_W-1:0] r_col, w_col_n;
    logic [SW-1:0]    r_settle, w_settle_n;
    logic             r_busy, r_fdone, r_cap;

    logic                w_go;
    pin_sel_e            w_sel;
    logic [CNT_W-1:0]    w_cnt;
    logic                w_pg_done;
    logic [NUM_PINS-1:0] w_pins;

    stonyman_pulse_gen #(
        .PULSE_CYCLES(PULSE_CYCLES)
    ) u_pulse (
        .clk     (clk),
        .reset   (reset),
        .i_sel   (w_sel),
        .i_count (w_cnt),
        .i_go    (w_go),
        .o_pins  (w_pins),
        .o_done  (w_pg_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_phase  <= 1'b0;
            r_row    <= '0;
            r_col    <= '0;
            r_settle <= '0;
            r_busy   <= 1'b0;
            r_fdone  <= 1'b0;
            r_cap    <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_phase  <= w_phase_n;
            r_row    <= w_row_n;
            r_col    <= w_col_n;
            r_settle <= w_settle_n;
            r_busy   <= (w_state_n != S_IDLE);
            r_fdone  <= (w_state_n == S_DONE);
            r_cap    <= (w_state_n == S_CAPTURE);
        end
    end

    // Each pulse burst is launched on the edge that enters its state, and the
    // next burst on the previous one's final low cycle, so bursts abut.
    always_comb begin
        w_state_n  = r_state;
        w_phase_n  = r_phase;
        w_row_n    = r_row;
        w_col_n    = r_col;
        w_settle_n = r_settle;
        w_go       = 1'b0;
        w_sel      = PIN_RESP;
        w_cnt      = CNT_W'(1);
        case (r_state)
            S_IDLE: begin
                if (frame_start) begin
                    w_state_n = S_ROW_PTR;
                    w_phase_n = 1'b0;
                    w_row_n   = '0;
                    w_go      = 1'b1;
                    w_sel     = PIN_RESP;
                end
            end
            S_ROW_PTR: begin
                if (w_pg_done) begin
                    w_go = 1'b1;
                    if (!r_phase) begin
                        w_sel     = PIN_INCP;
                        w_cnt     = ROW_PTR_INCS;
                        w_phase_n = 1'b1;
                    end else begin
                        w_sel     = PIN_RESV;
                        w_state_n = S_ROW_VAL;
                        w_phase_n = 1'b0;
                    end
                end
            end
            S_ROW_VAL: begin
                if (w_pg_done) begin
                    w_go = 1'b1;
                    if (!r_phase && r_row != '0) begin
                        w_sel     = PIN_INCV;
                        w_cnt     = r_row;
                        w_phase_n = 1'b1;
                    end else begin
                        w_sel     = PIN_RESP;
                        w_state_n = S_COL_PTR;
                        w_phase_n = 1'b0;
                    end
                end
            end
            S_COL_PTR: begin
                if (w_pg_done) begin
                    if (!r_phase) begin
                        w_go      = 1'b1;
                        w_sel     = PIN_RESV;
                        w_phase_n = 1'b1;
                    end else begin
                        w_state_n  = S_SETTLE;
                        w_phase_n  = 1'b0;
                        w_col_n    = '0;
                        w_settle_n = SETTLE_LOAD;
                    end
                end
            end
            S_SETTLE: begin
                if (r_settle == '0) w_state_n  = S_CAPTURE;
                else                w_settle_n = r_settle - 1'b1;
            end
            S_CAPTURE: w_state_n = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (adc_capture_done) begin
                    if (r_col < LAST_COL) begin
                        w_col_n   = r_col + 1'b1;
                        w_state_n = S_COL_STEP;
                        w_go      = 1'b1;
                        w_sel     = PIN_INCV;
                    end else if (r_row < LAST_ROW) begin
                        w_row_n   = r_row + 1'b1;
                        w_state_n = S_ROW_PTR;
                        w_phase_n = 1'b0;
                        w_go      = 1'b1;
                        w_sel     = PIN_RESP;
                    end else begin
                        w_state_n = S_DONE;
                    end
                end
            end
            S_COL_STEP: begin
                if (w_pg_done) begin
                    w_state_n  = S_SETTLE;
                    w_settle_n = SETTLE_LOAD;
                end
            end
            S_DONE:  w_state_n = S_IDLE;
            default: w_state_n = S_IDLE;
        endcase
    end

    assign resp              = w_pins[PIN_RESP];
    assign incp              = w_pins[PIN_INCP];
    assign resv              = w_pins[PIN_RESV];
    assign incv              = w_pins[PIN_INCV];
    assign frame_busy        = r_busy;
    assign frame_done        = r_fdone;
    assign adc_capture_start = r_cap;

endmodule

// File: tb/tb_stonyman_pixel_sequencer.sv
// Bench for stonyman_pixel_sequencer: a sensor model reconstructs the row/col
// register values at each capture and checks them against queued pixels.
module tb_stonyman_pixel_sequencer;

    localparam int R   = 2;
    localparam int C   = 3;
    localparam int PC  = 1;
    localparam int ST  = 4;
    localparam int GAP = 2*PC + ST + 1;

    typedef struct {
        int dly; bit busy_start; bit inj_settle;
        int caps; int resp_n; int incp_n; int resv_n; int incv_n; int fdone;
    } vec_t;
    typedef struct { int r; int c; } pix_t;
    typedef struct { int r; int c; int gap; } cap_t;

    logic clk = 1'b0;
    logic reset, frame_start, adc_capture_done;
    logic frame_busy, frame_done, resp, incp, resv, incv, adc_capture_start;
    logic auto_done, inj_done;

    assign adc_capture_done = auto_done | inj_done;

    stonyman_pixel_sequencer #(
        .ROWS(R), .COLS(C), .PULSE_CYCLES(PC), .SETTLE_CYCLES(ST)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .frame_start       (frame_start),
        .frame_busy        (frame_busy),
        .frame_done        (frame_done),
        .resp              (resp),
        .incp              (incp),
        .resv              (resv),
        .incv              (incv),
        .adc_capture_start (adc_capture_start),
        .adc_capture_done  (adc_capture_done)
    );

    always #5 clk = ~clk;

    int dly = 5;
    bit hold = 1'b0;
    bit noise = 1'b0;

    // ADC model: done pulse dly cycles after each capture start
    initial begin : responder
        int pend;
        pend = 0;
        auto_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            auto_done = 1'b0;
            if (reset) pend = 0;
            else if (pend > 0) begin
                pend--;
                if (pend == 0) auto_done = 1'b1;
            end else if (adc_capture_start && !hold) pend = dly;
        end
    end

    int cyc = 0, n_cap = 0, n_resp = 0, n_incp = 0, n_resv = 0, n_incv = 0;
    int n_fdone = 0, n_onehot = 0, fd_lat = 0, last_done = 0, ptr = 0;
    int sreg [2] = '{0, 0};
    logic [3:0] prev = 4'b0;
    cap_t acts [1024];

    always @(negedge clk) begin : monitor
        logic [3:0] pins;
        cyc++;
        pins = {incv, resv, incp, resp};
        if ($countones(pins) > 1) n_onehot++;
        if (pins[0] && !prev[0]) begin n_resp++; ptr = 0; end
        if (pins[1] && !prev[1]) begin n_incp++; ptr++; end
        if (pins[2] && !prev[2]) begin n_resv++; if (ptr < 2) sreg[ptr] = 0; end
        if (pins[3] && !prev[3]) begin n_incv++; if (ptr < 2) sreg[ptr]++; end
        prev = pins;
        if (adc_capture_done && !noise) last_done = cyc;
        if (frame_done) begin n_fdone++; fd_lat = cyc - last_done; end
        if (adc_capture_start) begin
            if (n_cap < 1024) acts[n_cap] = '{sreg[1], sreg[0], cyc - last_done};
            n_cap++;
        end
    end

    int n_vec = 0, n_err = 0, rd = 0;
    pix_t exp_q[$];
    vec_t vt [3];

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic push_frame();
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) exp_q.push_back('{r, c});
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 frame_start = 1'b1;
        @(posedge clk); #1 frame_start = 1'b0;
    endtask

    task automatic wait_caps(input int target);
        int t;
        t = 0;
        while (n_cap < target && t < 5000) begin @(negedge clk); t++; end
        check("capture_timeout", int'(n_cap >= target), 1);
    endtask

    task automatic wait_fdone(input int base);
        int t;
        t = 0;
        while (n_fdone == base && t < 5000) begin @(negedge clk); t++; end
        check("frame_done_timeout", int'(n_fdone > base), 1);
    endtask

    task automatic drain(input bit expect_all);
        pix_t p;
        cap_t a;
        while (rd < n_cap && rd < 1024) begin
            a = acts[rd];
            if (exp_q.size() == 0) begin
                check("extra_captures", n_cap - rd, 0);
                rd = n_cap;
            end else begin
                p = exp_q.pop_front();
                check("pixel_row", a.r, p.r);
                check("pixel_col", a.c, p.c);
                if (p.c != 0) check("col_step_gap", a.gap, GAP);
                rd++;
            end
        end
        if (expect_all) check("missing_captures", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic run_vec(input vec_t v);
        int b_cap, b_resp, b_incp, b_resv, b_incv, b_fd, b_oh, t;
        b_cap = n_cap; b_resp = n_resp; b_incp = n_incp; b_resv = n_resv;
        b_incv = n_incv; b_fd = n_fdone; b_oh = n_onehot;
        dly = v.dly;
        push_frame();
        pulse_start();
        @(negedge clk);
        check("busy_after_start", frame_busy, 1);
        check("resp_after_start", resp, 1);
        if (v.busy_start) begin
            repeat (30) @(posedge clk);
            #1 frame_start = 1'b1;
            @(posedge clk); #1 frame_start = 1'b0;
        end
        if (v.inj_settle) begin
            t = 0;
            while (!adc_capture_done && t < 2000) begin @(negedge clk); t++; end
            check("inject_wait_timeout", int'(t < 2000), 1);
            repeat (4) @(posedge clk);
            #1 noise = 1'b1; inj_done = 1'b1;
            @(posedge clk); #1 inj_done = 1'b0; noise = 1'b0;
        end
        wait_fdone(b_fd);
        repeat (300) @(negedge clk);
        check("captures", n_cap - b_cap, v.caps);
        check("resp_pulses", n_resp - b_resp, v.resp_n);
        check("incp_pulses", n_incp - b_incp, v.incp_n);
        check("resv_pulses", n_resv - b_resv, v.resv_n);
        check("incv_pulses", n_incv - b_incv, v.incv_n);
        check("frame_done_count", n_fdone - b_fd, v.fdone);
        check("frame_done_latency", fd_lat, 1);
        check("busy_after_frame", frame_busy, 0);
        check("pin_onehot_violations", n_onehot - b_oh, 0);
        drain(1'b1);
    endtask

    initial begin : main
        int act, b_fd, b_cap;
        reset = 1'b1; frame_start = 1'b0; inj_done = 1'b0;
        vt[0] = '{5, 1'b0, 1'b0, 6, 4, 2, 4, 5, 1};
        vt[1] = '{5, 1'b1, 1'b1, 6, 4, 2, 4, 5, 1};
        vt[2] = '{2, 1'b0, 1'b0, 6, 4, 2, 4, 5, 1};

        @(negedge clk);
        check("reset_outputs",
              int'({frame_busy, frame_done, resp, incp, resv, incv, adc_capture_start}), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        act = 0;
        repeat (100) begin
            @(negedge clk);
            if ({frame_busy, frame_done, resp, incp, resv, incv, adc_capture_start} != 7'b0) act++;
        end
        check("idle_activity", act, 0);

        for (int i = 0; i < 3; i++) run_vec(vt[i]);

        // Reset during WAIT_DONE of pixel (1,1), then a clean rescan
        b_fd = n_fdone;
        dly = 40;
        push_frame();
        pulse_start();
        wait_caps(rd + 5);
        repeat (3) @(posedge clk);
        #1 check("busy_in_wait_done", frame_busy, 1);
        #2 reset = 1'b1;
        #1 check("reset_async_outputs",
                 int'({frame_busy, frame_done, resp, incp, resv, incv, adc_capture_start}), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        drain(1'b0);
        repeat (60) @(negedge clk);
        check("no_frame_done_after_reset", n_fdone - b_fd, 0);
        check("idle_after_reset", frame_busy, 0);
        run_vec(vt[0]);

        // Withheld done: FSM parks in WAIT_DONE
        hold = 1'b1;
        dly = 5;
        b_fd = n_fdone;
        b_cap = n_cap;
        push_frame();
        pulse_start();
        wait_caps(b_cap + 1);
        act = 0;
        repeat (1000) begin
            @(negedge clk);
            if ({resp, incp, resv, incv, adc_capture_start} != 5'b0) act++;
        end
        check("hold_pin_activity", act, 0);
        check("hold_busy", frame_busy, 1);
        check("hold_captures", n_cap - b_cap, 1);
        @(posedge clk); #1 hold = 1'b0; inj_done = 1'b1;
        @(posedge clk); #1 inj_done = 1'b0;
        wait_fdone(b_fd);
        repeat (20) @(negedge clk);
        check("hold_total_captures", n_cap - b_cap, R*C);
        drain(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/stonyman_pixel_sequencer.md
Name: stonyman_pixel_sequencer

Overview:
- Upstream stage of adc_controller.
- Drives the Stonyman image sensor's pointer/value pins (RESP, INCP, RESV, INCV) to raster-scan one frame pixel by pixel.
- For each pixel it waits a settle time, issues a one-cycle adc_capture_start, then waits for adc_capture_done before stepping to the next column.
- Sits between the MSS frame-control registers and adc_controller; runs on the same 40 MHz clock.

Parameters:
- ROWS, 112, rows scanned per frame (1..127).
- COLS, 112, columns scanned per row (1..127).
- PULSE_CYCLES, 2, clk cycles a pin is held high, and also cycles held low after it, per pulse (>=1).
- SETTLE_CYCLES, 20, clk cycles of pixel-amplifier settling before each capture (>=1).

Ports:
- clk  in  1  system clock, 40 MHz.
- reset  in  1  asynchronous reset, active-high.
- frame_start  in  1  one-cycle request to scan a frame; ignored while frame_busy=1.
- frame_busy  out  1  high from the cycle after an accepted frame_start until frame_done.
- frame_done  out  1  one-cycle pulse after the last pixel's adc_capture_done.
- resp  out  1  sensor pointer reset.
- incp  out  1  sensor pointer increment.
- resv  out  1  sensor value reset.
- incv  out  1  sensor value increment.
- adc_capture_start  out  1  one-cycle capture request to adc_controller.
- adc_capture_done  in  1  one-cycle pulse from adc_controller; the current pixel is sampled.

Behaviour:
- Reset (async): state IDLE; all outputs 0; row and column counters 0.
- All outputs are registered.
- Pin pulses:
  - One pulse is PULSE_CYCLES high followed by PULSE_CYCLES low.
  - N pulses on one pin take 2*N*PULSE_CYCLES cycles.
  - N=0 takes 0 cycles; the state is skipped.
  - At most one of resp/incp/resv/incv is high in any cycle.
- Sensor register pointers: 0 = column select, 1 = row select.
- States and transitions:
  - IDLE: on frame_start go to ROW_PTR; frame_busy<=1; row<=0.
  - ROW_PTR: resp x1, then incp x1 (pointer = row select) -> ROW_VAL.
  - ROW_VAL: resv x1, then incv x row -> COL_PTR.
  - COL_PTR: resp x1 (pointer = column select), then resv x1; col<=0 -> SETTLE.
  - SETTLE: count SETTLE_CYCLES with all pins low -> CAPTURE.
  - CAPTURE: adc_capture_start=1 for exactly one cycle -> WAIT_DONE.
  - WAIT_DONE: wait for adc_capture_done, with no timeout.
    - If col<COLS-1: col+1 -> COL_STEP.
    - Else if row<ROWS-1: row+1 -> ROW_PTR.
    - Else -> DONE.
  - COL_STEP: incv x1 -> SETTLE.
  - DONE: frame_done=1 for one cycle; frame_busy<=0 -> IDLE.
- adc_capture_done is ignored in every state except WAIT_DONE.
- If adc_capture_done arrives in the same cycle as frame_start in IDLE, only frame_start acts.
- frame_start while busy is dropped; it is not queued.
- Counters: 7 bits each.
  - The incv count for ROW_VAL equals the row counter value.
  - Counters never wrap within a frame.
- Per-pixel latency, non-first column: 2*PULSE_CYCLES + SETTLE_CYCLES + 1 + (cycles until done).
- Reset asserted mid-frame: all pins drop low immediately (asynchronously). After release: IDLE, no frame_done issued.

Decomposition:
- Shared package (stonyman_defs): state encodings, pointer indices (PTR_COL=0, PTR_ROW=1), pin-select encoding, counter widths.
- Sub-module stonyman_pulse_gen:
  - Inputs: pin select, 7-bit pulse count, go.
  - Outputs: one-hot pin bus, done.
  - Owns the PULSE_CYCLES high/low timer and the pulse counter; the sequencer FSM only sequences requests.

Test Plan:
- Idle after reset, no frame_start for 100 cycles -> all outputs 0, frame_busy=0.
- ROWS=2, COLS=3, PULSE_CYCLES=1, SETTLE_CYCLES=4; adc_capture_done model replies 5 cycles after each start.
  - Exactly 6 adc_capture_start pulses.
  - Row 0: resp, incp, resv pulses and 0 incv pulses before the first capture.
  - Row 1: exactly 1 incv pulse in ROW_VAL.
  - frame_done one cycle after the 6th done.
- Same config: cycle gap from the first done of row 0 to the next adc_capture_start -> 2+4+1 = 7 cycles (COL_STEP + SETTLE + CAPTURE).
- frame_start pulsed while busy, and adc_capture_done injected during SETTLE -> no second frame; capture count unchanged; no premature column step.
- Reset asserted during WAIT_DONE of pixel (1,1) -> pins low the same cycle; no frame_done; a fresh frame_start rescans from row 0 with 6 captures.
- adc_capture_done withheld for 1000 cycles -> FSM stays in WAIT_DONE, no pin activity, frame_busy=1.
